piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//  Parallel-in serial-out serializer: the transmit end of the 4-bit SIPO serial link.
//  Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per CLK.
//  Supports back-to-back words with no idle gap. With LSB_FIRST=1, SOUT wired to SIPO.IN
//  reproduces DIN on SIPO.Q exactly WIDTH clocks after the first bit appears.
// PARAMETERS
//  WIDTH      4   word length in bits; legal range 2..32
//  LSB_FIRST  1   1: DIN[0] is sent first; 0: DIN[WIDTH-1] is sent first
//  IDLE_LEVEL 0   value driven on SOUT while no word is being sent
// PORTS
//  CLK         in   1      rising-edge clock, sole clock domain
//  RST         in   1      asynchronous, active-high reset
//  DIN         in   WIDTH  parallel word; sampled only on an accepted load
//  LOAD_VALID  in   1      producer presents DIN
//  LOAD_READY  out  1      serializer can accept a word this cycle
//  SOUT        out  1      serial data out
//  SOUT_VALID  out  1      SOUT carries a payload bit this cycle
//  DONE        out  1      high during the cycle the last bit of a word is on SOUT
//  BUSY        out  1      a word is being shifted (state == SHIFT)
// BEHAVIOUR
//  Reset (RST=1, async, dominates everything):
//   - state=IDLE; shift register=0; bit counter=0.
//   - SOUT=IDLE_LEVEL, SOUT_VALID=0, DONE=0, BUSY=0, LOAD_READY=0 while RST=1.
//  State machine IDLE, SHIFT; registers shreg[WIDTH-1:0] and cnt[$clog2(WIDTH)-1:0].
//  Load acceptance: accept = LOAD_VALID & LOAD_READY, evaluated at a rising CLK.
//   - LOAD_READY = !RST & (state==IDLE | (state==SHIFT & cnt==0)).
//   - On accept: shreg<=DIN, cnt<=WIDTH-1, state<=SHIFT.
//   - LOAD_VALID with LOAD_READY=0 is ignored; DIN is not sampled. The producer holds the word.
//  IDLE:
//   - SOUT=IDLE_LEVEL, SOUT_VALID=0, DONE=0, BUSY=0.
//  SHIFT:
//   - SOUT = shreg[0] if LSB_FIRST, else shreg[WIDTH-1]. SOUT_VALID=1, BUSY=1.
//   - Each CLK: shift toward the output end, fill with 0, cnt<=cnt-1.
//   - cnt==0 marks the last bit: DONE=1.
//   - Next state: SHIFT (reload) on accept, else IDLE.
//  Latency and throughput:
//   - First bit appears on SOUT the cycle after accept.
//   - Exactly WIDTH SOUT_VALID cycles per word.
//   - Continuous LOAD_VALID gives 100% link utilisation: the new word's first bit follows
//     the previous word's last bit on the next cycle.
//  All outputs are combinational decodes of registered state only; there is no input-to-output
//  combinational path except LOAD_READY from RST.
//  Reset mid-word: the word is aborted and no DONE is issued; after RST falls, behaviour is
//  identical to power-up.
// TESTING
//  - Reset: assert RST mid-SHIFT, async, between edges -> SOUT=IDLE_LEVEL, SOUT_VALID=0,
//    BUSY=0 immediately; no DONE.
//  - Single word, WIDTH=4, LSB_FIRST=1, DIN=4'b1011 -> SOUT=1,1,0,1 on cycles 1..4 after accept;
//    DONE only on cycle 4; LOAD_READY=0 on cycles 1..3.
//  - Loopback into 4-bit SIPO: DIN=4'hA -> SIPO.Q==4'hA on the edge after the 4th bit;
//    repeat for all 16 values.
//  - Back-to-back: LOAD_VALID held high, words 4'h3 then 4'hC -> 8 consecutive SOUT_VALID
//    cycles, SOUT=1,1,0,0,0,0,1,1; DONE on cycles 4 and 8.
//  - Backpressure: LOAD_VALID=1 with changing DIN during cycles 1..3 -> ignored; only the DIN
//    present when LOAD_READY=1 is sent.
//  - LSB_FIRST=0, WIDTH=8, DIN=8'h81 -> SOUT=1,0,0,0,0,0,0,1; idle SOUT=IDLE_LEVEL
//    (run with IDLE_LEVEL=1).

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: accepts a WIDTH-bit word over a valid/ready
// handshake and shifts it out one bit per clock, with back-to-back reload on the last bit.
module piso_serializer #(
    parameter int unsigned WIDTH      = 4,
    parameter bit          LSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    output logic             sout_o,
    output logic             sout_valid_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             busy_q;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             accept;

    assign accept = load_valid_i & ready_q;

    // Next-state: load on accept, otherwise shift toward the output end with zero fill.
    always_comb begin
        state_d = state_q;
        shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
        cnt_d   = cnt_q;
        if (accept) begin
            shreg_d = din_i;
            cnt_d   = CNT_LAST;
            state_d = S_SHIFT;
        end else if (state_q == S_SHIFT && cnt_q != '0) begin
            cnt_d   = cnt_q - CW'(1);
        end else begin
            state_d = S_IDLE;
        end
        sout_d  = IDLE_LEVEL;
        if (state_d == S_SHIFT) begin
            sout_d = LSB_FIRST ? shreg_d[0] : shreg_d[WIDTH-1];
        end
        done_d  = (state_d == S_SHIFT) && (cnt_d == '0);
        ready_d = (state_d == S_IDLE) || (cnt_d == '0);
    end

    // Registered state plus the output flags derived from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sout_q  <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            busy_q  <= (state_d == S_SHIFT);
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    // Ready is forced low while reset is held, even before the first edge.
    assign load_ready_o = ready_q & ~rst_i;
    assign sout_o       = sout_q;
    assign sout_valid_o = busy_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
